// File: rtl/layer7_pkg.sv
// Shared definitions for the layer-7 controller: FSM state encoding and
// default layer dimensions.
package layer7_pkg;

  localparam int unsigned DEF_NUM_BEATS = 16;
  localparam int unsigned DEF_NUM_OUT   = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/layer7_controller.sv
// Sequencer for one fully-connected layer pass. For each output neuron it
// clears the accumulator, streams NUM_BEATS input/weight beats, waits one
// cycle for the last beat and the bias read, then writes the result.
//
// Ports:
//   clk, rst         clock, async active-low reset
//   start            run one layer pass (sampled only in IDLE)
//   busy, done       status; done is a single-cycle pulse
//   rd_en, in_addr,  input/weight buffer read strobe and addresses
//   w_addr
//   b_rd_en, b_addr  bias buffer read strobe and address
//   acc_clr, acc_en  datapath accumulator clear / accumulate
//   out_we, out_addr result capture strobe and neuron index
module layer7_controller
  import layer7_pkg::*;
#(
  parameter  int unsigned NUM_BEATS = DEF_NUM_BEATS,
  parameter  int unsigned NUM_OUT   = DEF_NUM_OUT,
  localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
  localparam int unsigned W_W       = (NUM_BEATS * NUM_OUT > 1) ? $clog2(NUM_BEATS * NUM_OUT) : 1,
  localparam int unsigned OUT_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [BEAT_W-1:0] in_addr,
  output logic [W_W-1:0]    w_addr,
  output logic              b_rd_en,
  output logic [OUT_W-1:0]  b_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_we,
  output logic [OUT_W-1:0]  out_addr
);

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [OUT_W-1:0]   neuron_q, neuron_d;
  logic               beat_last, neuron_last;

  logic               busy_d, done_d, rd_en_d, b_rd_en_d;
  logic               acc_clr_d, out_we_d;
  logic [BEAT_W-1:0]  in_addr_d;
  logic [W_W-1:0]     w_addr_d;
  logic [OUT_W-1:0]   b_addr_d, out_addr_d;

  assign beat_last   = (beat_q == BEAT_W'(NUM_BEATS - 1));
  assign neuron_last = (neuron_q == OUT_W'(NUM_OUT - 1));

  // Next state and counters; outputs are decoded from the *next* state so
  // that, once registered, they line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    neuron_d   = neuron_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    b_rd_en_d  = 1'b0;
    acc_clr_d  = 1'b0;
    out_we_d   = 1'b0;
    in_addr_d  = '0;
    w_addr_d   = '0;
    b_addr_d   = '0;
    out_addr_d = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CLEAR;
          neuron_d = '0;
        end
      end
      CLEAR: begin
        state_d = RUN;
        beat_d  = '0;
      end
      RUN: begin
        // beat holds at its last value so it never wraps mid-pass
        if (beat_last) state_d = DRAIN;
        else           beat_d  = beat_q + BEAT_W'(1);
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        if (neuron_last) begin
          state_d = DONE;
        end else begin
          state_d  = CLEAR;
          neuron_d = neuron_q + OUT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    acc_clr_d = (state_d == CLEAR);
    rd_en_d   = (state_d == RUN);
    b_rd_en_d = (state_d == DRAIN);
    out_we_d  = (state_d == WRITE);
    if (rd_en_d) begin
      in_addr_d = beat_d;
      w_addr_d  = W_W'(neuron_d) * W_W'(NUM_BEATS) + W_W'(beat_d);
    end
    if (b_rd_en_d) b_addr_d   = neuron_d;
    if (out_we_d)  out_addr_d = neuron_d;
  end

  // State, counters and registered outputs. acc_en is rd_en delayed one
  // cycle to match the 1-cycle buffer read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      neuron_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      in_addr  <= '0;
      w_addr   <= '0;
      b_rd_en  <= 1'b0;
      b_addr   <= '0;
      acc_clr  <= 1'b0;
      acc_en   <= 1'b0;
      out_we   <= 1'b0;
      out_addr <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      neuron_q <= neuron_d;
      busy     <= busy_d;
      done     <= done_d;
      rd_en    <= rd_en_d;
      in_addr  <= in_addr_d;
      w_addr   <= w_addr_d;
      b_rd_en  <= b_rd_en_d;
      b_addr   <= b_addr_d;
      acc_clr  <= acc_clr_d;
      acc_en   <= rd_en;
      out_we   <= out_we_d;
      out_addr <= out_addr_d;
    end
  end

endmodule

// File: doc/layer7_controller.md
LAYER7_CONTROLLER -- requirements
Module: layer7_controller

Interface
REQ-001 Parameter NUM_BEATS, default 16, SHALL set the number of 8-lane (128-bit) input/weight beats accumulated per output neuron (min 1).
REQ-002 Parameter NUM_OUT, default 10, SHALL set the number of output neurons computed per start (min 1).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: request to run one full layer pass; sampled only in IDLE.
REQ-006 Port busy, output, 1: high in every state except IDLE.
REQ-007 Port done, output, 1: one-cycle pulse when the pass has completed.
REQ-008 Port rd_en, output, 1: read strobe to the input and weight buffers, which have 1-cycle read latency.
REQ-009 Port in_addr, output, $clog2(NUM_BEATS) (min 1): input-buffer beat address.
REQ-010 Port w_addr, output, $clog2(NUM_BEATS*NUM_OUT) (min 1): weight-buffer address.
REQ-011 Port b_rd_en, output, 1: read strobe to the bias buffer, which has 1-cycle read latency.
REQ-012 Port b_addr, output, $clog2(NUM_OUT) (min 1): bias address.
REQ-013 Port acc_clr, output, 1: synchronous clear of the datapath accumulator register.
REQ-014 Port acc_en, output, 1: accumulate enable of the datapath accumulator register.
REQ-015 Port out_we, output, 1: write strobe capturing the datapath's biased 16-bit result.
REQ-016 Port out_addr, output, $clog2(NUM_OUT) (min 1): result write address, i.e. the neuron index.

Function
REQ-017 States SHALL be IDLE, CLEAR, RUN, DRAIN, WRITE and DONE, with internal counters beat (0..NUM_BEATS-1) and neuron (0..NUM_OUT-1).
REQ-018 IDLE SHALL transition to CLEAR on start=1 and clear neuron to 0; it SHALL stay in IDLE otherwise.
REQ-019 CLEAR SHALL assert acc_clr for exactly 1 cycle, set beat to 0 and transition to RUN.
REQ-020 RUN SHALL assert rd_en with in_addr=beat and w_addr=neuron*NUM_BEATS+beat, and increment beat each cycle.
REQ-021 RUN SHALL transition to DRAIN in the cycle where beat=NUM_BEATS-1.
REQ-022 acc_en SHALL equal rd_en delayed by one registered cycle, so that it aligns with buffer data.
REQ-023 DRAIN SHALL last 1 cycle, during which acc_en for the last beat is high; it SHALL assert b_rd_en with b_addr=neuron and transition to WRITE.
REQ-024 WRITE SHALL assert out_we with out_addr=neuron for 1 cycle, with acc_en=0 and acc_clr=0.
REQ-025 WRITE SHALL go to DONE if neuron=NUM_OUT-1; otherwise it SHALL increment neuron and go to CLEAR.
REQ-026 DONE SHALL assert done for 1 cycle and return to IDLE; start SHALL be ignored in every non-IDLE state, including DONE.
REQ-027 Each neuron SHALL take exactly NUM_BEATS+3 cycles, and done SHALL assert NUM_OUT*(NUM_BEATS+3)+1 cycles after the start-accepting edge.
REQ-028 acc_clr and acc_en SHALL never be high in the same cycle, and rd_en SHALL never be high outside RUN.
REQ-029 Address arithmetic SHALL be unsigned, and the counters SHALL never wrap mid-pass.

Reset
REQ-030 While rst=0, the state SHALL be IDLE and beat, neuron and all outputs SHALL be 0, including the acc_en delay register.
REQ-031 Reset asserted mid-pass SHALL abort the pass immediately, with no done pulse and no further out_we.
REQ-032 After reset release, the block SHALL require a new start to run.

Structure
REQ-033 Package layer7_pkg SHALL hold the state enum typedef and the default NUM_BEATS/NUM_OUT constants.
REQ-034 The block SHALL contain no sub-module: the FSM and counters are inline, and the datapath is instantiated alongside it by the parent.

Verification
REQ-035 Default parameters, start pulse -> neuron 0 reads w_addr 0..15, neuron 9 reads w_addr 144..159; out_we at out_addr 0..9; done exactly 191 cycles after start.
REQ-036 start held high throughout a pass -> exactly one pass runs; a second pass begins only when start is sampled in IDLE after done.
REQ-037 rst=0 asserted during RUN of neuron 3 -> all outputs 0 asynchronously; no done; idle until the next start.
REQ-038 NUM_BEATS=1, NUM_OUT=1 -> sequence CLEAR, RUN, DRAIN, WRITE, DONE; done at cycle 5; acc_en high only in DRAIN.
REQ-039 Paired with the datapath, all inputs 1.0 (16'h0400), weights 1.0 and bias 0, NUM_BEATS=2 -> each captured result equals 16'h4000 (16.0).
REQ-040 Assertions over every pass -> acc_clr and acc_en never high together; out_we count equals NUM_OUT; done is a single-cycle pulse.
